// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-stage request and hazard/forwarding response bundle.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
   logic             i_dec_valid;
   logic [4:0]       i_dec_rs;
   logic [4:0]       i_dec_rt;
   logic             i_dec_use_rs;
   logic             i_dec_use_rt;
   logic [4:0]       i_dec_wr_addr;
   logic             i_dec_reg_write;
   logic             i_dec_mem_to_reg;
   logic [1:0]       i_pcsrc;
   logic             i_exception;
   logic [1:0]       o_mux_ctrl1;
   logic [1:0]       o_mux_ctrl2;
   logic             o_stall;
   logic             o_bubble;
   logic             o_flush_if_id;
   logic [CNT_W-1:0] o_stall_cnt;
   modport slave (
      input  i_dec_valid, i_dec_rs, i_dec_rt, i_dec_use_rs, i_dec_use_rt,
             i_dec_wr_addr, i_dec_reg_write, i_dec_mem_to_reg, i_pcsrc, i_exception,
      output o_mux_ctrl1, o_mux_ctrl2, o_stall, o_bubble, o_flush_if_id, o_stall_cnt
   );
   modport master (
      output i_dec_valid, i_dec_rs, i_dec_rt, i_dec_use_rs, i_dec_use_rt,
             i_dec_wr_addr, i_dec_reg_write, i_dec_mem_to_reg, i_pcsrc, i_exception,
      input  o_mux_ctrl1, o_mux_ctrl2, o_stall, o_bubble, o_flush_if_id, o_stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage stall/forward/flush control from an EX/MEM/WB destination scoreboard.
module hazard_ctrl #(parameter int CNT_W = 16) (
   input  logic          i_clk,
   input  logic          i_rst,
   hazard_ctrl_if.slave  bus
);
   typedef struct packed {
      logic       valid;
      logic       we;
      logic       mtr;
      logic [4:0] wa;
   } slot_t;

   slot_t            ex_q, mem_q, wb_q, ex_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req1, req2;
   logic [1:0]       sel1, sel2;

   function automatic logic hit(slot_t x, logic [4:0] s);
      return x.valid && x.we && x.wa == s && s != 5'd0;
   endfunction

   // {stall request, select}; an EX hit can only be resolved by waiting one cycle
   function automatic logic [2:0] fwd(logic use_s, logic [4:0] s, slot_t ex, slot_t mem, slot_t wb);
      return !use_s      ? 3'b000 :
             hit(ex, s)  ? 3'b100 :
             hit(mem, s) ? {1'b0, mem.mtr ? 2'b10 : 2'b01} :
             hit(wb, s)  ? 3'b011 : 3'b000;
   endfunction

   always_comb begin
      {req1, sel1} = fwd(bus.i_dec_use_rs, bus.i_dec_rs, ex_q, mem_q, wb_q);
      {req2, sel2} = fwd(bus.i_dec_use_rt, bus.i_dec_rt, ex_q, mem_q, wb_q);
      ex_d = (bus.o_stall || bus.i_exception || !bus.i_dec_valid) ? '0 :
             {1'b1, bus.i_dec_reg_write, bus.i_dec_mem_to_reg, bus.i_dec_wr_addr};
      cnt_d = (bus.o_stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end

   assign bus.o_mux_ctrl1   = sel1;
   assign bus.o_mux_ctrl2   = sel2;
   assign bus.o_stall       = bus.i_dec_valid & (req1 | req2);
   assign bus.o_bubble      = bus.o_stall | bus.i_exception;
   assign bus.o_flush_if_id = bus.i_exception | ((bus.i_pcsrc != 2'b00) & ~bus.o_stall);
   assign bus.o_stall_cnt   = cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed vectors plus reset and counter-saturation sequences.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   pass_cnt = 0;
   int   total = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(16)) bus ();
   hazard_ctrl_if #(.CNT_W(2))  bus2 ();

   hazard_ctrl #(.CNT_W(16)) dut  (.i_clk(clk), .i_rst(rst), .bus(bus));
   hazard_ctrl #(.CNT_W(2))  dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

   typedef struct {
      logic       v;
      logic [4:0] rs, rt;
      logic       urs, urt;
      logic [4:0] wa;
      logic       we, mtr;
      logic [1:0] pc;
      logic       exc;
      int         m1, m2, st, bu, fl, cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                      input int wa, input logic we, input logic mtr, input int pc, input logic exc,
                      input int m1, input int m2, input int st, input int bu, input int fl, input int cnt);
      vec_t x;
      x.v = v; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt;
      x.wa = 5'(wa); x.we = we; x.mtr = mtr; x.pc = 2'(pc); x.exc = exc;
      x.m1 = m1; x.m2 = m2; x.st = st; x.bu = bu; x.fl = fl; x.cnt = cnt;
      vecs.push_back(x);
   endtask

   task automatic drive(input vec_t x);
      bus.i_dec_valid = x.v;
      bus.i_dec_rs = x.rs;
      bus.i_dec_rt = x.rt;
      bus.i_dec_use_rs = x.urs;
      bus.i_dec_use_rt = x.urt;
      bus.i_dec_wr_addr = x.wa;
      bus.i_dec_reg_write = x.we;
      bus.i_dec_mem_to_reg = x.mtr;
      bus.i_pcsrc = x.pc;
      bus.i_exception = x.exc;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_all(input string tag, input int m1, input int m2, input int st,
                            input int bu, input int fl, input int cnt);
      check({tag, " mux1"}, int'(bus.o_mux_ctrl1), m1);
      check({tag, " mux2"}, int'(bus.o_mux_ctrl2), m2);
      check({tag, " stall"}, int'(bus.o_stall), st);
      check({tag, " bubble"}, int'(bus.o_bubble), bu);
      check({tag, " flush"}, int'(bus.o_flush_if_id), fl);
      check({tag, " cnt"}, int'(bus.o_stall_cnt), cnt);
   endtask

   int sat_exp[5] = '{1, 2, 3, 3, 3};
   vec_t idle;

   initial begin
      //   v  rs  rt urs urt wa we mtr pc exc | m1 m2 st bu fl cnt
      add(1,  1,  2, 1, 1,  3, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
      add(1,  3,  0, 1, 1,  8, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0);
      add(1,  3,  0, 1, 1,  8, 1, 0, 0, 0,   1, 0, 0, 0, 0, 1);
      add(1,  9, 10, 1, 1, 11, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
      add(1, 12, 13, 1, 1, 14, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
      add(1,  0,  8, 1, 1, 15, 1, 0, 0, 0,   0, 3, 0, 0, 0, 1);
      add(1,  0,  0, 0, 0,  3, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
      add(1,  1,  2, 1, 1, 16, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
      add(1,  1,  2, 1, 1, 17, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1);
      add(1,  3,  0, 1, 0,  0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 1);
      add(1,  1,  0, 1, 0,  4, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1);
      add(1,  4,  4, 1, 1,  0, 0, 0, 1, 0,   0, 0, 1, 1, 0, 1);
      add(1,  4,  4, 1, 1,  0, 0, 0, 1, 0,   2, 2, 0, 0, 1, 2);
      add(1,  0,  0, 0, 0,  7, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2);
      add(1,  0,  0, 0, 0,  7, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2);
      add(1,  0,  0, 0, 0, 20, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2);
      add(1,  7,  0, 1, 0,  0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 2);
      add(1,  0,  0, 1, 1, 21, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2);
      add(1, 21,  0, 1, 0, 22, 1, 0, 0, 1,   0, 0, 1, 1, 1, 2);
      add(1, 22,  0, 1, 0, 24, 1, 0, 0, 0,   0, 0, 0, 0, 0, 3);
      add(1, 24,  0, 0, 0, 25, 1, 0, 2, 0,   0, 0, 0, 0, 1, 3);
      add(0, 25,  0, 1, 0, 26, 1, 0, 0, 0,   0, 0, 0, 0, 0, 3);
      add(1, 25, 24, 1, 1, 27, 1, 0, 0, 0,   1, 3, 0, 0, 0, 3);

      idle = '{v: 0, rs: 0, rt: 0, urs: 0, urt: 0, wa: 0, we: 0, mtr: 0, pc: 0, exc: 0,
               m1: 0, m2: 0, st: 0, bu: 0, fl: 0, cnt: 0};
      bus2.i_dec_valid = 0; bus2.i_dec_rs = 0; bus2.i_dec_rt = 0;
      bus2.i_dec_use_rs = 0; bus2.i_dec_use_rt = 0; bus2.i_dec_wr_addr = 0;
      bus2.i_dec_reg_write = 0; bus2.i_dec_mem_to_reg = 0; bus2.i_pcsrc = 0; bus2.i_exception = 0;

      // reset held while decode asks for $5
      rst = 1'b1;
      drive(idle);
      bus.i_dec_valid = 1; bus.i_dec_rs = 5'd5; bus.i_dec_use_rs = 1;
      #1 check_all("reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk); @(negedge clk);
      check_all("reset held", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1 check_all($sformatf("vec%0d", i), vecs[i].m1, vecs[i].m2, vecs[i].st,
                      vecs[i].bu, vecs[i].fl, vecs[i].cnt);
      end

      // reset during an active stall ($27 sits in EX)
      @(negedge clk);
      drive(idle);
      bus.i_dec_valid = 1; bus.i_dec_rs = 5'd27; bus.i_dec_use_rs = 1;
      #1 check("pre-reset stall", int'(bus.o_stall), 1);
      rst = 1'b1;
      #1 check_all("mid-stall reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      check_all("mid-stall reset held", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(idle);

      // self-dependent $5 op stalls every other cycle on the 2-bit counter
      bus2.i_dec_valid = 1; bus2.i_dec_rs = 5'd5; bus2.i_dec_use_rs = 1;
      bus2.i_dec_wr_addr = 5'd5; bus2.i_dec_reg_write = 1;
      #1 check("sat first no stall", int'(bus2.o_stall), 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         check($sformatf("sat stall %0d", k), int'(bus2.o_stall), 1);
         @(negedge clk); #1;
         check($sformatf("sat cnt %0d", k), int'(bus2.o_stall_cnt), sat_exp[k]);
         check($sformatf("sat fwd %0d", k), int'(bus2.o_mux_ctrl1), 1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
